mult_table_collector: RTL

- Downstream consumer of the multiplication-table sequencer / multiplier stage.
- Captures each 16-bit product into a first-word-fall-through (FWFT) FIFO and drains it over a valid/ready interface.
- Keeps a running per-row sum of accepted products and emits one row-sum pulse per completed row; the sequencer's done pulse (in_last) flushes a partial row.

---
 rtl/mult_table_collector.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/mult_table_collector.sv
// mult_table_collector
//   Downstream consumer of the multiplication-table sequencer / multiplier.
//   Every accepted product goes into a first-word-fall-through FIFO that is
//   drained over valid/ready. In parallel, a running per-row sum is kept and
//   one row-sum pulse is produced per completed row of ROW_LEN products. The
//   sequencer's done pulse (in_last) flushes a partial row and restarts the
//   row index at 0.
//
//   Build option:
//     COLLECT_SATURATE_EN  defined   -> row accumulator clamps at 2^SUM_W-1
//                          undefined -> row accumulator wraps modulo 2^SUM_W
//
//   Ports:
//     clk, rst        clock (rising edge), synchronous active-high reset
//     in_valid        product valid
//     in_data         product value (DATA_W)
//     in_last         end of table; flushes a partial row
//     out_valid       FIFO head valid
//     out_ready       downstream accepts head
//     out_data        FIFO head (0 while empty)
//     row_sum_valid   one-cycle pulse, new row sum
//     row_sum         last emitted row sum, held between pulses
//     out_row         row index belonging to row_sum
//     fifo_count      current FIFO occupancy
//     full            fifo_count == DEPTH
//     overflow        sticky; a push was dropped because the FIFO was full
module mult_table_collector #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ROW_LEN = 8,
  parameter int unsigned SUM_W   = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     row_sum_valid,
  output logic [SUM_W-1:0]         row_sum,
  output logic [7:0]               out_row,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     full,
  output logic                     overflow
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned RCW = $clog2(ROW_LEN + 1);

  // ---------------------------------------------------------------- FIFO
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              push;
  logic              pop;
  logic              drop;

  assign out_valid  = (count != '0);
  assign full       = (count == CW'(DEPTH));
  assign fifo_count = count;
  assign out_data   = out_valid ? mem[rd_ptr] : '0;

  assign pop  = out_valid && out_ready;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------- row summing
  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_EMIT
  } state_t;

  state_t         state;
  state_t         state_n;
  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] acc_n;
  logic [SUM_W-1:0] acc_add;
  logic [RCW-1:0]   cnt;
  logic [RCW-1:0]   cnt_n;
  logic [7:0]       row_idx;
  logic             emit;
  logic             emit_flush;
  logic [SUM_W-1:0] emit_sum;

`ifdef COLLECT_SATURATE_EN
  logic [SUM_W:0] sum_wide;
  assign sum_wide = {1'b0, acc} + (SUM_W + 1)'(in_data);
  // Clamped value is all-ones, so any further non-zero add carries again
  // and the clamp is held until the row is emitted.
  assign acc_add  = sum_wide[SUM_W] ? '1 : sum_wide[SUM_W-1:0];
`else
  assign acc_add  = acc + SUM_W'(in_data);
`endif

  // The completed sum is registered on the completing edge, so row_sum and
  // out_row are already valid during the EMIT cycle that drives the pulse.
  // EMIT otherwise behaves like IDLE: a push in that cycle opens a new row.
  always_comb begin
    state_n    = state;
    acc_n      = acc;
    cnt_n      = cnt;
    emit       = 1'b0;
    emit_flush = 1'b0;
    emit_sum   = acc;
    case (state)
      S_ACCUM: begin
        if (push) begin
          acc_n = acc_add;
          cnt_n = cnt + RCW'(1);
        end
        if ((push && (cnt_n == RCW'(ROW_LEN))) || in_last) begin
          emit       = 1'b1;
          emit_flush = in_last;
          emit_sum   = acc_n;
        end
      end
      default: begin
        if (push) begin
          acc_n   = SUM_W'(in_data);
          cnt_n   = RCW'(1);
          state_n = S_ACCUM;
          if ((ROW_LEN == 1) || in_last) begin
            emit       = 1'b1;
            emit_flush = in_last;
            emit_sum   = acc_n;
          end
        end else begin
          acc_n   = '0;
          cnt_n   = '0;
          state_n = S_IDLE;
        end
      end
    endcase
    if (emit) begin
      state_n = S_EMIT;
      acc_n   = '0;
      cnt_n   = '0;
    end
  end

  assign row_sum_valid = (state == S_EMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      acc     <= '0;
      cnt     <= '0;
      row_idx <= '0;
      row_sum <= '0;
      out_row <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      if (emit) begin
        row_sum <= emit_sum;
        out_row <= row_idx;
        row_idx <= emit_flush ? '0 : row_idx + 8'd1;
      end else if (in_last && !push && (state != S_ACCUM)) begin
        row_idx <= '0;
      end
    end
  end

endmodule
